// File: rtl/rom_tone_sequencer_pkg.sv
// Shared constants, FSM state type and amplitude helper for the ROM tone sequencer.
// No logic of its own; imported by the sequencer top and its oscillator.
package rom_tone_sequencer_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;

   localparam logic [31:0] REST_CODE       = 32'h0000_0000;
   localparam logic [31:0] END_CODE        = 32'hFFFF_FFFF;
   localparam int          DEF_BEAT_CYCLES = 2500000;
   localparam int          DEF_AMP         = 100000000;

   function automatic logic signed [31:0] scaled_amp(input logic signed [31:0] amp,
                                                     input logic [2:0]         vol);
      return amp >>> vol;
   endfunction

endpackage

// File: rtl/rom_tone_sequencer_if.sv
// Control, note-ROM and audio-sample signals of the tone sequencer.
// slave = sequencer side, master = board top / testbench side.
interface rom_tone_sequencer_if #(
   parameter int TRACK_W = 2,
   parameter int STEP_W  = 10,
   parameter int DELAY_W = 19
);
   logic                      play;
   logic                      stop;
   logic                      loop_en;
   logic [TRACK_W-1:0]        track_sel;
   logic [2:0]                volume;
   logic [TRACK_W+STEP_W-1:0] rom_addr;
   logic [DELAY_W-1:0]        rom_q;
   logic                      audio_out_allowed;
   logic [31:0]               sample_out;
   logic                      write_audio_out;
   logic                      busy;
   logic                      done;

   modport master (
      output play, stop, loop_en, track_sel, volume, rom_q, audio_out_allowed,
      input  rom_addr, sample_out, write_audio_out, busy, done
   );

   modport slave (
      input  play, stop, loop_en, track_sel, volume, rom_q, audio_out_allowed,
      output rom_addr, sample_out, write_audio_out, busy, done
   );
endinterface

// File: rtl/rom_tone_sequencer_square_osc.sv
// Square-wave generator: snd toggles every i_half enabled cycles; clear forces snd=0.
// Latency: toggle visible the cycle after half_cnt reaches i_half-1; no backpressure.
module rom_tone_sequencer_square_osc
   import rom_tone_sequencer_pkg::*;
#(
   parameter int DELAY_W = 19
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic [DELAY_W-1:0] i_half,
   input  logic               i_en,
   input  logic               i_clr,
   output logic               o_snd
);
   logic [DELAY_W-1:0] r_half_cnt;
   logic               r_snd;
   logic [DELAY_W-1:0] w_half_last;

   assign w_half_last = i_half - DELAY_W'(1);
   assign o_snd       = r_snd;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_half_cnt <= '0;
         r_snd      <= 1'b0;
      end else if (i_clr) begin
         r_half_cnt <= '0;
         r_snd      <= 1'b0;
      end else if (i_en) begin
         if (r_half_cnt == w_half_last) begin
            r_half_cnt <= '0;
            r_snd      <= ~r_snd;
         end else begin
            r_half_cnt <= r_half_cnt + DELAY_W'(1);
         end
      end
   end

endmodule

// File: rtl/rom_tone_sequencer.sv
// Plays a track of half-period words from an external 1-cycle note ROM as a square wave.
// Latency: first sample 4 cycles after play, 2 silent cycles between notes; no backpressure.
module rom_tone_sequencer
   import rom_tone_sequencer_pkg::*;
#(
   parameter int TRACK_W     = 2,
   parameter int STEP_W      = 10,
   parameter int DELAY_W     = 19,
   parameter int BEAT_CYCLES = DEF_BEAT_CYCLES,
   parameter int AMP         = DEF_AMP
) (
   input  logic                 CLOCK_50,
   input  logic                 resetn,
   rom_tone_sequencer_if.slave  bus
);
   localparam int                  BEAT_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
   localparam logic [DELAY_W-1:0]  W_END     = END_CODE[DELAY_W-1:0];
   localparam logic [DELAY_W-1:0]  W_REST    = REST_CODE[DELAY_W-1:0];
   localparam logic signed [31:0]  AMP_S     = AMP;
   localparam logic [STEP_W-1:0]   STEP_ZERO = '0;

   state_t                    r_state;
   logic [TRACK_W-1:0]        r_track;
   logic [STEP_W-1:0]         r_step;
   logic [DELAY_W-1:0]        r_note;
   logic [BEAT_W-1:0]         r_beat_cnt;
   logic [TRACK_W+STEP_W-1:0] r_rom_addr;
   logic signed [31:0]        r_sample;
   logic                      r_busy;
   logic                      r_done;

   logic                      w_snd;
   logic                      w_osc_en;
   logic                      w_osc_clr;
   logic signed [31:0]        w_amp;
   logic signed [31:0]        w_sample_nxt;
   logic [STEP_W-1:0]         w_step_nxt;

   assign w_osc_clr    = (r_state == WAIT);
   assign w_osc_en     = (r_state == PLAY) && (r_note != W_REST);
   assign w_amp        = scaled_amp(AMP_S, bus.volume);
   assign w_sample_nxt = w_osc_en ? (w_snd ? w_amp : -w_amp) : 32'sd0;
   assign w_step_nxt   = r_step + STEP_W'(1);

   rom_tone_sequencer_square_osc #(.DELAY_W(DELAY_W)) u_osc (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .i_half   (r_note),
      .i_en     (w_osc_en),
      .i_clr    (w_osc_clr),
      .o_snd    (w_snd)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_track    <= '0;
         r_step     <= '0;
         r_note     <= '0;
         r_beat_cnt <= '0;
         r_rom_addr <= '0;
         r_sample   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_sample <= w_sample_nxt;
         if (bus.stop && (r_state != IDLE)) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_sample <= '0;
         end else if (bus.play) begin
            // The address is loaded on entry to FETCH so rom_q is valid by the end of WAIT.
            r_track    <= bus.track_sel;
            r_step     <= '0;
            r_rom_addr <= {bus.track_sel, STEP_ZERO};
            r_state    <= FETCH;
            r_busy     <= 1'b1;
            r_sample   <= '0;
         end else begin
            case (r_state)
               FETCH: r_state <= WAIT;
               WAIT: begin
                  r_note     <= bus.rom_q;
                  r_beat_cnt <= '0;
                  if (bus.rom_q == W_END) begin
                     if (bus.loop_en) begin
                        r_step     <= '0;
                        r_rom_addr <= {r_track, STEP_ZERO};
                        r_state    <= FETCH;
                     end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_state <= PLAY;
                  end
               end
               PLAY: begin
                  if (r_beat_cnt == BEAT_LAST) begin
                     r_beat_cnt <= '0;
                     // Running off the last step counts as an end marker.
                     if ((&r_step) && !bus.loop_en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_step     <= w_step_nxt;
                        r_rom_addr <= {r_track, w_step_nxt};
                        r_state    <= FETCH;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.rom_addr        = r_rom_addr;
   assign bus.sample_out      = r_sample;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.write_audio_out = bus.audio_out_allowed & resetn;

endmodule
